// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller: op codes, FSM states and
// small op-class predicates used by the controller and the lane logic.
package mem_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic is_load(input logic [2:0] op);
        return op <= OP_LBU;
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return op >= OP_SW;
    endfunction

    // Sub-word stores need the old word first so they can be merged.
    function automatic logic is_subword(input logic [2:0] op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Little-endian byte/half lane steering: extracts load values from a memory
// word and merges sub-word store data into a previously read word.
module dm_lane
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word[{addr, 3'b000} +: 8];
        lane_half = addr[1] ? word[31:16] : word[15:0];

        case (op)
            OP_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_data = {24'd0, lane_byte};
            OP_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_data = {16'd0, lane_half};
            default: load_data = word;
        endcase

        store_word = word;
        case (op)
            OP_SB: store_word[{addr, 3'b000} +: 8] = wdata[7:0];
            OP_SH: begin
                if (addr[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
            end
            OP_SW:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Load/store controller between the MEM stage and the word-wide data memory;
// one request at a time, sub-word stores done as read-modify-write.
module dm_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DM_BYTES = 12288
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [13:0] dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);

    localparam logic [31:0] LAST_WORD = 32'(DM_BYTES - 4);

    state_e      state;
    state_e      next_state;
    logic [2:0]  op_q;
    logic [13:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] din_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        range_err;
    logic        align_err;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept = req_valid && req_ready;

    always_comb begin
        range_err = (req_addr[31:14] != 18'd0) ||
                    ({18'd0, req_addr[13:2], 2'b00} > LAST_WORD);
        case (req_op)
            OP_LW, OP_SW:         align_err = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: align_err = req_addr[0];
            default:              align_err = 1'b0;
        endcase
        req_err = range_err || align_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        next_state = ST_RESP;
                    else if (req_op == OP_SW)
                        next_state = ST_WR;
                    else
                        next_state = ST_RD;
                end
            end
            ST_RD:   next_state = is_subword(op_q) ? ST_WR : ST_RESP;
            ST_WR:   next_state = ST_RESP;
            ST_RESP: next_state = resp_ready ? ST_IDLE : ST_RESP;
            default: next_state = ST_IDLE;
        endcase
    end

    // Write enable is decoded from state so an async reset kills it at once.
    always_comb begin
        req_ready  = (state == ST_IDLE) && rst_n;
        resp_valid = (state == ST_RESP);
        dm_we      = (state == ST_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_LW;
            addr_q  <= 14'd0;
            wdata_q <= 32'd0;
            din_q   <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr[13:0];
            wdata_q <= req_wdata;
            din_q   <= req_wdata;
            rdata_q <= 32'd0;
            err_q   <= req_err;
        end else if (state == ST_RD) begin
            if (is_load(op_q))
                rdata_q <= load_data;
            else
                din_q <= store_word;
        end
    end

    dm_lane u_lane (
        .op         (op_q),
        .addr       (addr_q[1:0]),
        .word       (dm_dout),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    assign dm_addr    = {addr_q[13:2], 2'b00};
    assign dm_din     = din_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed and randomized bench for dm_ctrl against a byte-array memory model
// that applies the load/store rules directly to individual bytes.
module tb_dm_ctrl;
    import mem_pkg::*;

    localparam logic [31:0] TB_DM_BYTES = 32'd12288;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [13:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [0:4095] = '{default: 32'h0};
    logic [7:0]  ref_mem [0:12287] = '{default: 8'h00};

    int checks = 0;
    int errors = 0;

    string op_name [8] = '{"LW", "LH", "LHU", "LB", "LBU", "SW", "SH", "SB"};

    dm_ctrl #(.DM_BYTES(12288)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_we      (dm_we),
        .dm_dout    (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr[13:2]];

    always @(posedge clk) begin
        if (dm_we)
            mem[dm_addr[13:2]] <= dm_din;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] base;
        base = addr & ~32'd3;
        return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
    endfunction

    // Expected outcome of one request; stores update the byte model.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err, output int n,
                         output int wes, output logic [31:0] wword);
        int sz;
        logic [31:0] val;
        sz = (op == OP_LW || op == OP_SW) ? 4 :
             (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        err = (addr >= TB_DM_BYTES) || ((addr % sz) != 0);
        rd = 32'd0;
        wes = 0;
        wword = 32'd0;
        if (err) begin
            n = 1;
        end else if (op >= OP_SW) begin
            for (int i = 0; i < sz; i++)
                ref_mem[addr + i] = 8'(wdata >> (8 * i));
            wword = ref_word(addr);
            wes = 1;
            n = (op == OP_SW) ? 2 : 3;
        end else begin
            val = 32'd0;
            for (int i = 0; i < sz; i++)
                val = val | (32'(ref_mem[addr + i]) << (8 * i));
            if (op == OP_LB && val[7])
                val = val | 32'hFFFF_FF00;
            if (op == OP_LH && val[15])
                val = val | 32'hFFFF_0000;
            rd = val;
            n = 2;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int t;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_output("req_ready_before_send", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic collect(output logic [31:0] rd, output logic err, output int n,
                           output int wes, output logic [13:0] wa, output logic [31:0] wd);
        n = 1;
        wes = 0;
        wa = 14'd0;
        wd = 32'd0;
        while (1) begin
            if (dm_we) begin
                wes++;
                wa = dm_addr;
                wd = dm_din;
            end
            if (resp_valid || n >= 20)
                break;
            @(posedge clk);
            #1;
            n++;
        end
        rd = resp_rdata;
        err = resp_err;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_output("resp_valid_after_handshake", 32'(resp_valid), 32'd0);
        check_output("req_ready_after_handshake", 32'(req_ready), 32'd1);
    endtask

    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, output logic [31:0] got);
        logic [31:0] e_rd, e_word, rd, wd;
        logic        e_err, err;
        int          e_n, e_wes, n, wes;
        logic [13:0] wa;
        string       tag;
        tag = $sformatf("%s@%h", op_name[op], addr);
        model(op, addr, wdata, e_rd, e_err, e_n, e_wes, e_word);
        send(op, addr, wdata);
        collect(rd, err, n, wes, wa, wd);
        check_output({tag, " rdata"}, rd, e_rd);
        check_output({tag, " err"}, 32'(err), 32'(e_err));
        check_output({tag, " latency"}, 32'(n), 32'(e_n));
        check_output({tag, " we_pulses"}, 32'(wes), 32'(e_wes));
        if (e_wes != 0) begin
            check_output({tag, " we_addr"}, 32'(wa), addr & 32'h0000_3FFC);
            check_output({tag, " we_data"}, wd, e_word);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_output({tag, " hold_valid"}, 32'(resp_valid), 32'd1);
            check_output({tag, " hold_rdata"}, resp_rdata, e_rd);
            check_output({tag, " hold_ready"}, 32'(req_ready), 32'd0);
        end
        handshake();
        got = rd;
    endtask

    initial begin
        logic [31:0] got, e_rd, e_word, rd, wd, addr;
        logic        e_err, err;
        int          e_n, e_wes, n, wes, sel;
        logic [13:0] wa;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = OP_LW;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;

        #2;
        check_output("reset resp_valid", 32'(resp_valid), 32'd0);
        check_output("reset resp_err", 32'(resp_err), 32'd0);
        check_output("reset resp_rdata", resp_rdata, 32'd0);
        check_output("reset dm_we", 32'(dm_we), 32'd0);
        check_output("reset dm_addr", 32'(dm_addr), 32'd0);
        check_output("reset dm_din", dm_din, 32'd0);
        check_output("reset req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_output("req_ready after reset", 32'(req_ready), 32'd1);

        $display("[TB] case 1: SW then LW");
        run_req(OP_SW, 32'h10, 32'hA1B2_C3D4, 0, got);
        run_req(OP_LW, 32'h10, 32'h0, 0, got);
        check_output("c1 LW const", got, 32'hA1B2_C3D4);

        $display("[TB] case 2: sub-word loads");
        run_req(OP_LB, 32'h13, 32'h0, 0, got);
        check_output("c2 LB const", got, 32'hFFFF_FFA1);
        run_req(OP_LBU, 32'h13, 32'h0, 0, got);
        check_output("c2 LBU const", got, 32'h0000_00A1);
        run_req(OP_LH, 32'h12, 32'h0, 0, got);
        check_output("c2 LH const", got, 32'hFFFF_A1B2);
        run_req(OP_LHU, 32'h10, 32'h0, 0, got);
        check_output("c2 LHU const", got, 32'h0000_C3D4);

        $display("[TB] case 3: sub-word stores");
        run_req(OP_SB, 32'h11, 32'h0000_00EE, 0, got);
        run_req(OP_SH, 32'h12, 32'h0000_1234, 0, got);
        run_req(OP_LW, 32'h10, 32'h0, 0, got);
        check_output("c3 LW const", got, 32'h1234_EED4);

        $display("[TB] case 4: error accesses");
        run_req(OP_LW, 32'h11, 32'h0, 0, got);
        run_req(OP_SH, 32'h13, 32'h5555_5555, 0, got);
        run_req(OP_SW, 32'h3000, 32'h5555_5555, 0, got);
        run_req(OP_LB, 32'h0001_0000, 32'h0, 0, got);

        $display("[TB] case 5: response back-pressure");
        model(OP_LW, 32'h10, 32'h0, e_rd, e_err, e_n, e_wes, e_word);
        send(OP_LW, 32'h10, 32'h0);
        collect(rd, err, n, wes, wa, wd);
        check_output("c5 rdata", rd, e_rd);
        check_output("c5 latency", 32'(n), 32'(e_n));
        req_valid = 1'b1;
        req_op    = OP_LW;
        req_addr  = 32'h14;
        req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_output("c5 hold_valid", 32'(resp_valid), 32'd1);
            check_output("c5 hold_rdata", resp_rdata, e_rd);
            check_output("c5 hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_output("c5 idle after handshake", 32'(req_ready), 32'd1);
        model(OP_LW, 32'h14, 32'h0, e_rd, e_err, e_n, e_wes, e_word);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output("c5 late accept", 32'(req_ready), 32'd0);
        collect(rd, err, n, wes, wa, wd);
        check_output("c5 pending rdata", rd, e_rd);
        check_output("c5 pending latency", 32'(n), 32'(e_n));
        handshake();

        $display("[TB] case 6: reset during store write");
        send(OP_SB, 32'h11, 32'h0000_0055);
        @(posedge clk);
        #1;
        check_output("c6 we in WR", 32'(dm_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("c6 we after reset", 32'(dm_we), 32'd0);
        check_output("c6 ready in reset", 32'(req_ready), 32'd0);
        check_output("c6 valid in reset", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_output("c6 ready after release", 32'(req_ready), 32'd1);
        check_output("c6 mem word", mem[4], ref_word(32'h10));
        run_req(OP_LW, 32'h10, 32'h0, 0, got);
        check_output("c6 LW const", got, 32'h1234_EED4);

        $display("[TB] random traffic");
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)
                addr = 32'($urandom_range(0, 63));
            else if (sel == 7)
                addr = 32'h2FF0 + 32'($urandom_range(0, 31));
            else if (sel == 8)
                addr = $urandom;
            else
                addr = 32'h3FFC + 32'($urandom_range(0, 3));
            run_req(3'($urandom_range(0, 7)), addr, $urandom, $urandom_range(0, 2), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Memory-access controller between the CPU datapath (MEM stage) and the 12 KB byte-addressed data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives the memory's word port (addr, din, we; dout read back combinationally).
- Implements LW/LH/LHU/LB/LBU/SW/SH/SB; sub-word stores are done as read-modify-write.
- Flags misaligned and out-of-range accesses; the CPU stalls on req_ready/resp_valid.

Parameters:
DM_BYTES, 12288, data memory size in bytes; must be a multiple of 4 and at most 16384.

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU presents a request
req_ready  output  1  controller can accept; high only in IDLE
req_op  input  3  operation code (see package)
req_addr  input  32  byte address
req_wdata  input  32  store data; the low byte or low half is used for SB/SH
resp_valid  output  1  response available; held until resp_ready
resp_ready  input  1  CPU consumes the response
resp_rdata  output  32  load result, extended per op; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range access; no memory write occurred
dm_addr  output  14  word-aligned byte address to memory: {req_addr[13:2],2'b00}
dm_din  output  32  write word to memory
dm_we  output  1  memory write enable, one cycle per store
dm_dout  input  32  memory read word for dm_addr

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0, dm_we=0, dm_addr=0, dm_din=0.
  - req_ready is forced 0 while rst_n is low.
  - Reset during RD or WR aborts the operation. dm_we is decoded from state, so it drops asynchronously and no partial write is committed after reset assertion.
- Accept: when req_valid && req_ready in IDLE, op, addr and wdata are registered. The request is checked in the same cycle.
- Error conditions:
  - req_addr[31:14] != 0, or {req_addr[13:2],2'b00} > DM_BYTES-4.
  - LW/SW with addr[1:0] != 0.
  - LH/LHU/SH with addr[0] != 0.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. The memory is never written.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RESP on error.
  - IDLE -> RD for loads, SH and SB.
  - IDLE -> WR for SW.
  - RD: dm_addr is driven and dm_dout is captured at the clock edge.
    - For loads: extracted value goes to resp_rdata, then -> RESP.
    - For SH/SB: captured word goes to a merge register, then -> WR.
  - WR: dm_we=1 for exactly one cycle. dm_din is wdata for SW, or the merged word for SH/SB. Then -> RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are stable until resp_ready=1, then -> IDLE.
  - A new request can be accepted from the cycle after the RESP handshake.
- Latency (accept edge = cycle 0, resp_valid first high at cycle N):
  - N=1 for errors.
  - N=2 for loads and SW.
  - N=3 for SH/SB.
  - Each additional cycle resp_ready is low adds one cycle.
- Lane rules (little-endian, byte k = word[8k+7:8k], k = addr[1:0], half h = addr[1]):
  - LB/LBU: byte k, sign- or zero-extended to 32 bits.
  - LH/LHU: word[16h+15:16h], sign- or zero-extended to 32 bits.
  - SB: replace byte k with wdata[7:0].
  - SH: replace half h with wdata[15:0].
  - All other bytes are preserved from the RD capture.
- dm_addr and dm_din are held from the registered request outside RD and WR. dm_we is 1 only in WR.
- req_valid in non-IDLE states is ignored (not accepted). resp_ready outside RESP has no effect.

Decomposition:
- Package mem_pkg:
  - Op codes: OP_LW=0, OP_LH=1, OP_LHU=2, OP_LB=3, OP_LBU=4, OP_SW=5, OP_SH=6, OP_SB=7.
  - FSM state encoding.
  - Predicates is_load, is_store, is_subword.
- One combinational sub-module, dm_lane:
  - Inputs: op, addr[1:0], the memory word and wdata.
  - Outputs: the extracted load value and the merged store word.
- The FSM and registers stay in dm_ctrl.

Test Plan:
- Case 1: SW addr 0x10, wdata 0xA1B2C3D4; then LW 0x10.
  - Required: a single dm_we pulse with dm_addr=0x10 and dm_din=0xA1B2C3D4, resp_valid at cycle 2.
  - Required: the LW returns 0xA1B2C3D4 with err=0.
- Case 2: from word 0xA1B2C3D4 at 0x10, run LB 0x13, LBU 0x13, LH 0x12, LHU 0x10.
  - Required: LB 0x13 -> 0xFFFFFFA1; LBU 0x13 -> 0x000000A1.
  - Required: LH 0x12 -> 0xFFFFA1B2; LHU 0x10 -> 0x0000C3D4.
- Case 3: SB 0x11 with wdata 0x000000EE, then SH 0x12 with wdata 0x00001234, then LW 0x10.
  - Required: LW returns 0x1234EED4.
  - Required: each store shows the RD then WR sequence with resp_valid at cycle 3.
- Case 4: error accesses LW 0x11, SH 0x13, SW 0x3000, LB 0x00010000.
  - Required: each gives resp_err=1, resp_rdata=0, resp_valid at cycle 1, and dm_we never asserts.
- Case 5: LW with resp_ready held low for 5 cycles.
  - Required: resp_valid and resp_rdata stay stable and req_ready stays 0.
  - Required: a request presented during the hold is not accepted; it is accepted in the cycle after the handshake.
- Case 6: rst_n asserted while in WR of an SB.
  - Required: dm_we drops immediately and the memory word is unchanged.
  - Required: after release, req_ready=1 and a following LW returns the original word.
